// File: rtl/borrow_skip_subtractor_pkg.sv
// rtl/borrow_skip_subtractor_pkg.sv - shared constants, FSM state type and block-count helper
package borrow_skip_subtractor_pkg;

    localparam int BLK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bss_state_t;

    function automatic int calc_blocks(input int width);
        return width / BLK_W;
    endfunction

endpackage

// File: rtl/borrow_skip_block.sv
// rtl/borrow_skip_block.sv - combinational 4-bit ripple-borrow slice with borrow-skip bypass
module borrow_skip_block
    import borrow_skip_subtractor_pkg::*;
(
    input  logic [BLK_W-1:0] a4,
    input  logic [BLK_W-1:0] b4,
    input  logic             bw_in,
    output logic [BLK_W-1:0] d4,
    output logic             bw_out
);

    logic [BLK_W-1:0] p;
    logic [BLK_W-1:0] g;
    logic [BLK_W:0]   bw;

    assign p     = ~(a4 ^ b4);
    assign g     = ~a4 & b4;
    assign bw[0] = bw_in;

    for (genvar i = 0; i < BLK_W; i++) begin : g_bit
        assign d4[i]   = a4[i] ^ b4[i] ^ bw[i];
        assign bw[i+1] = g[i] | (p[i] & bw[i]);
    end

    // When all bit pairs match the borrow-in propagates unchanged, so bypass the ripple.
    assign bw_out = (&p & bw_in) | bw[BLK_W];

endmodule

// File: rtl/borrow_skip_subtractor.sv
// rtl/borrow_skip_subtractor.sv - multi-cycle a-b-bin subtractor, one 4-bit block per clock; BSS_OVERFLOW_EN adds overflow
module borrow_skip_subtractor
    import borrow_skip_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BSS_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int BLOCKS = calc_blocks(WIDTH);
    localparam int IDX_W  = $clog2(BLOCKS + 1);

    bss_state_t       state;
    bss_state_t       state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             bw_r;
    logic [IDX_W-1:0] blk_idx;
    logic             last_blk;
    logic [BLK_W-1:0] blk_a;
    logic [BLK_W-1:0] blk_b;
    logic [BLK_W-1:0] blk_d;
    logic             blk_bw_out;

    assign last_blk  = (blk_idx == IDX_W'(BLOCKS - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        blk_a = '0;
        blk_b = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            if (blk_idx == IDX_W'(i)) begin
                blk_a = a_r[i*BLK_W +: BLK_W];
                blk_b = b_r[i*BLK_W +: BLK_W];
            end
        end
    end

    borrow_skip_block u_blk (
        .a4     (blk_a),
        .b4     (blk_b),
        .bw_in  (bw_r),
        .d4     (blk_d),
        .bw_out (blk_bw_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_blk)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            bw_r     <= 1'b0;
            blk_idx  <= '0;
            diff     <= '0;
            bout     <= 1'b0;
`ifdef BSS_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        bw_r    <= bin;
                        blk_idx <= '0;
                        diff    <= '0;
                    end
                end
                ST_RUN: begin
                    diff[int'(blk_idx)*BLK_W +: BLK_W] <= blk_d;
                    bw_r    <= blk_bw_out;
                    blk_idx <= blk_idx + IDX_W'(1);
                    if (last_blk) begin
                        bout     <= blk_bw_out;
`ifdef BSS_OVERFLOW_EN
                        // The top diff bit is produced by this final block, so use blk_d directly.
                        overflow <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ blk_d[BLK_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// tb/tb_borrow_skip_subtractor.sv - randomized self-checking bench for borrow_skip_subtractor
module tb_borrow_skip_subtractor;

    localparam int WIDTH  = 16;
    localparam int BLOCKS = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef BSS_OVERFLOW_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    borrow_skip_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BSS_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular and signed arithmetic on whole operands.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tbin, input int hold);
        logic [WIDTH:0]          full;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        int                      ia;
        int                      ib;
        int                      sr;
        logic [WIDTH-1:0]        exp_d;
        logic                    exp_b;
        logic                    exp_o;
        int                      lat;
        full  = {1'b0, ta} - {1'b0, tb_v} - {{WIDTH{1'b0}}, tbin};
        exp_d = full[WIDTH-1:0];
        exp_b = full[WIDTH];
        sa = ta;
        sb = tb_v;
        ia = sa;
        ib = sb;
        sr = ia - ib - int'(tbin);
        exp_o = (sr > 32767) || (sr < -32768);

        check_eq("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("latency", lat, BLOCKS);
        check_eq("diff", {16'b0, diff}, {16'b0, exp_d});
        check_eq("bout", {31'b0, bout}, {31'b0, exp_b});
`ifdef BSS_OVERFLOW_EN
        check_eq("overflow", {31'b0, overflow}, {31'b0, exp_o});
`endif
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            tick();
            check_eq("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check_eq("hold_diff", {16'b0, diff}, {16'b0, exp_d});
            check_eq("hold_bout", {31'b0, bout}, {31'b0, exp_b});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_diff", {16'b0, diff}, 32'd0);
        check_eq("rst_bout", {31'b0, bout}, 32'd0);
`ifdef BSS_OVERFLOW_EN
        check_eq("rst_overflow", {31'b0, overflow}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

        run_op(16'h1234, 16'h0234, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'hAAAA, 16'hAAAA, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 3);
        run_op(16'h0000, 16'hFFFF, 1'b1, 1);
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);

        // Reset asserted during the second RUN cycle discards the operation.
        a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midrun_rst_diff", {16'b0, diff}, 32'd0);
        check_eq("midrun_rst_bout", {31'b0, bout}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_op(16'h0005, 16'h0003, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
